// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM port, shared by instruction fetch and the LSB.
// Optional feature: define MEMARB_IOFULL_STALL_EN to hold IO stores while io_buffer_full is set.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_LO = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ok,
  output logic [31:0]       if_data,
  input  logic              lsb_en,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [1:0]        lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_ok,
  output logic [31:0]       lsb_rdata,
  input  logic              rob_flush
);
  // state | meaning
  // IDLE  | arbitrate between fetch and LSB, sample requests
  // READ  | issue byte addresses, capture each byte two edges later
  // WRITE | write one byte per edge
  // DONE  | ok pulse cycle, no request sampled

`ifdef MEMARB_IOFULL_STALL_EN
  localparam bit IOFULL_STALL = 1'b1;
`else
  localparam bit IOFULL_STALL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state;
  logic        last_lsb;
  logic        cur_if;
  logic        cur_io;
  logic [2:0]  left;
  logic [2:0]  nbytes;
  logic [2:0]  lsb_n;
  logic [31:0] shreg;
  logic [31:0] cap_word;
  logic [31:0] rd_word;
  logic        lsb_io;
  logic        store_blocked;
  logic        wr_stall;
  logic        if_req;
  logic        lsb_req;
  logic        pick_lsb;

  always_comb begin
    case (lsb_len)
      2'b00:   lsb_n = 3'd1;
      2'b01:   lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  assign lsb_io        = (lsb_addr[IO_SEL_LO+1:IO_SEL_LO] == 2'b11);
  assign store_blocked = IOFULL_STALL && lsb_io && io_buffer_full;
  assign wr_stall      = IOFULL_STALL && cur_io && io_buffer_full;

  // During a flush the fetch and load enables are stale; stores are committed and may go.
  assign if_req   = if_en && !rob_flush;
  assign lsb_req  = lsb_en && (lsb_wr ? !store_blocked : !rob_flush);
  assign pick_lsb = lsb_req && (!if_req || !last_lsb);

  // Bytes shift in from the top; the final word is right-aligned by the byte count.
  assign cap_word = {mem_din, shreg[31:8]};
  assign rd_word  = cap_word >> {3'd4 - nbytes, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_lsb  <= 1'b0;
      cur_if    <= 1'b0;
      cur_io    <= 1'b0;
      left      <= '0;
      nbytes    <= '0;
      shreg     <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      if_ok     <= 1'b0;
      lsb_ok    <= 1'b0;
      if_data   <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      if_ok  <= 1'b0;
      lsb_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_lsb) begin
            last_lsb <= 1'b1;
            cur_if   <= 1'b0;
            cur_io   <= lsb_io;
            mem_a    <= lsb_addr;
            nbytes   <= lsb_n;
            if (lsb_wr) begin
              state    <= S_WRITE;
              left     <= lsb_n;
              mem_wr   <= 1'b1;
              mem_dout <= lsb_wdata[7:0];
              shreg    <= lsb_wdata >> 8;
            end else begin
              state <= S_READ;
              left  <= lsb_n + 3'd1;
              shreg <= '0;
            end
          end else if (if_req) begin
            last_lsb <= 1'b0;
            cur_if   <= 1'b1;
            cur_io   <= 1'b0;
            mem_a    <= if_addr;
            nbytes   <= 3'd4;
            state    <= S_READ;
            left     <= 3'd5;
            shreg    <= '0;
          end
        end
        S_READ: begin
          if (rob_flush) begin
            state <= S_IDLE;
            mem_a <= '0;
          end else begin
            left  <= left - 3'd1;
            mem_a <= (left > 3'd2) ? mem_a + ADDR_W'(1) : '0;
            if (left <= nbytes) shreg <= cap_word;
            if (left == 3'd1) begin
              state <= S_DONE;
              if (cur_if) begin
                if_data <= rd_word;
                if_ok   <= 1'b1;
              end else begin
                lsb_rdata <= rd_word;
                lsb_ok    <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          // A stalled byte is re-presented with mem_wr raised again once the buffer drains.
          if (wr_stall) begin
            mem_wr <= 1'b0;
          end else if (!mem_wr) begin
            mem_wr <= 1'b1;
          end else if (left == 3'd1) begin
            mem_wr <= 1'b0;
            mem_a  <= '0;
            lsb_ok <= 1'b1;
            state  <= S_DONE;
          end else begin
            left     <= left - 3'd1;
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= shreg[7:0];
            shreg    <= shreg >> 8;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed vectors with literal expectations.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, mem_wr, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        if_en, if_ok;
  logic [31:0] if_addr, if_data;
  logic        lsb_en, lsb_wr, lsb_ok, rob_flush;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [1:0]  lsb_len;

`ifdef MEMARB_IOFULL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata), .rob_flush(rob_flush)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int n_if_ok = 0;
  int n_lsb_ok = 0;

  // RAM seen by the DUT (one registered read stage) and the model's own copy
  logic [7:0] ram    [bit [31:0]];
  logic [7:0] shadow [bit [31:0]];
  logic [7:0] ram_q = 8'h00;
  assign mem_din = ram_q;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction
  function automatic int len_bytes(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      ram_q <= ram_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    shadow[a] = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a grant at effective edge E0 schedules outputs at E0+k
  bit          m_busy, m_was_busy, m_if, m_wr, m_last_lsb;
  bit          m_el_if, m_el_lsb, m_take_lsb;
  int          m_k, m_n;
  logic [31:0] m_addr, m_wdata, m_rdata, m_tmp;
  logic [31:0] e_a, e_if_data, e_lsb_rdata;
  logic [7:0]  e_dout;
  logic        e_wr, e_if_ok, e_lsb_ok;
  bit          e_a_chk, e_dout_chk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_last_lsb = 0;
      e_a = 0; e_dout = 0; e_wr = 0; e_if_ok = 0; e_lsb_ok = 0;
      e_if_data = 0; e_lsb_rdata = 0; e_a_chk = 1; e_dout_chk = 1;
    end else if (rdy) begin
      e_if_ok = 0; e_lsb_ok = 0; e_wr = 0; e_a_chk = 0; e_dout_chk = 0;
      m_was_busy = m_busy;
      if (m_busy) begin
        m_k++;
        if (!m_wr) begin
          if (rob_flush && m_k <= m_n + 1) begin
            m_busy = 0; e_a = 0; e_a_chk = 1;
          end else if (m_k < m_n) begin
            e_a = m_addr + 32'(m_k); e_a_chk = 1;
          end else if (m_k == m_n + 1) begin
            if (m_if) begin e_if_ok = 1; e_if_data = m_rdata; end
            else begin e_lsb_ok = 1; e_lsb_rdata = m_rdata; end
          end else if (m_k == m_n + 2) begin
            m_busy = 0;
          end
        end else begin
          if (m_k < m_n) begin
            m_tmp = m_wdata >> (8 * m_k);
            e_wr = 1; e_a = m_addr + 32'(m_k); e_dout = m_tmp[7:0];
            e_a_chk = 1; e_dout_chk = 1;
            shadow[e_a] = e_dout;
          end else if (m_k == m_n) begin
            e_a = 0; e_a_chk = 1; e_lsb_ok = 1;
          end else begin
            m_busy = 0;
          end
        end
      end
      if (!m_was_busy) begin
        m_el_if  = if_en && !rob_flush;
        m_el_lsb = lsb_en && (lsb_wr ? !(STALL && lsb_addr[17:16] == 2'b11 && io_buffer_full)
                                     : !rob_flush);
        m_take_lsb = (m_el_if && m_el_lsb) ? !m_last_lsb : m_el_lsb;
        if (m_el_if || m_el_lsb) begin
          m_busy = 1; m_k = 0; m_last_lsb = m_take_lsb; m_if = !m_take_lsb;
          m_wr = m_take_lsb && lsb_wr;
          m_addr = m_take_lsb ? lsb_addr : if_addr;
          m_n = m_take_lsb ? len_bytes(lsb_len) : 4;
          m_wdata = lsb_wdata;
          e_a = m_addr; e_a_chk = 1;
          if (m_wr) begin
            e_wr = 1; e_dout = m_wdata[7:0]; e_dout_chk = 1;
            shadow[m_addr] = m_wdata[7:0];
          end else begin
            m_rdata = 0;
            for (int i = 0; i < m_n; i++) m_rdata |= 32'(sh_rd(m_addr + 32'(i))) << (8 * i);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mem_wr", mem_wr, e_wr);
      chk("if_ok", if_ok, e_if_ok);
      chk("lsb_ok", lsb_ok, e_lsb_ok);
      chk("if_data", if_data, e_if_data);
      chk("lsb_rdata", lsb_rdata, e_lsb_rdata);
      if (e_a_chk) chk("mem_a", mem_a, e_a);
      if (e_dout_chk) chk("mem_dout", mem_dout, e_dout);
      if (if_ok) n_if_ok++;
      if (lsb_ok) n_lsb_ok++;
    end
  end

  task automatic go_if(input logic [31:0] a);
    if_addr = a; if_en = 1;
  endtask
  task automatic go_lsb(input logic w, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    lsb_wr = w; lsb_addr = a; lsb_len = l; lsb_wdata = d; lsb_en = 1;
  endtask
  task automatic wait_ok(input bit want_if, input string nm, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (want_if ? if_ok : lsb_ok) begin lat = i; break; end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s: got no ok pulse expected one within 40 cycles", nm);
    end
  endtask
  task automatic gap;
    if_en = 0; lsb_en = 0; rob_flush = 0;
    repeat (2) @(negedge clk);
  endtask

  int lat, base_if, base_lsb;
  logic [31:0] seq [4];

  initial begin
    rst_n = 0; rdy = 1; io_buffer_full = 0; rob_flush = 0;
    if_en = 0; if_addr = 0; lsb_en = 0; lsb_wr = 0; lsb_addr = 0; lsb_len = 0; lsb_wdata = 0;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h11, 8'h34); preload(32'h12, 8'h12);
    preload(32'hFFFF_FFFE, 8'h78); preload(32'hFFFF_FFFF, 8'h9A);
    preload(32'h0, 8'h11); preload(32'h1, 8'h22);

    @(negedge clk); chk_on = 1;
    chk("rst mem_a", mem_a, 32'h0);       chk("rst mem_dout", mem_dout, 8'h00);
    chk("rst mem_wr", mem_wr, 1'b0);      chk("rst if_ok", if_ok, 1'b0);
    chk("rst lsb_ok", lsb_ok, 1'b0);      chk("rst if_data", if_data, 32'h0);
    chk("rst lsb_rdata", lsb_rdata, 32'h0);
    rst_n = 1; @(negedge clk);

    // fetch alone
    go_if(32'h100); wait_ok(1, "if lat", lat);
    chk("if lat", lat, 6); chk("if word", if_data, 32'h0000_0513); gap();

    // store word then read back
    go_lsb(1, 32'h2000, 2'b11, 32'hDEAD_BEEF); wait_ok(0, "st lat", lat);
    chk("st lat", lat, 5); gap();
    go_lsb(0, 32'h2000, 2'b11, 0); wait_ok(0, "ld back", lat);
    chk("ld back", lsb_rdata, 32'hDEAD_BEEF); gap();

    // simultaneous requests after an IF grant: LSB wins
    go_if(32'h100); wait_ok(1, "pre if", lat); gap();
    base_if = n_if_ok; base_lsb = n_lsb_ok;
    go_if(32'h100); go_lsb(0, 32'h11, 2'b01, 0);
    wait_ok(0, "dual lsb", lat);
    chk("dual lsb lat", lat, 4); chk("dual if pending", n_if_ok, base_if);
    chk("dual half", lsb_rdata, 32'h0000_1234);
    lsb_en = 0;
    wait_ok(1, "dual if", lat);
    chk("dual if lat", lat, 7); gap();
    chk("dual if once", n_if_ok, base_if + 1); chk("dual lsb once", n_lsb_ok, base_lsb + 1);

    // flush during a fetch, then flush while idle
    base_if = n_if_ok; base_lsb = n_lsb_ok;
    go_if(32'h100); repeat (3) @(negedge clk);
    rob_flush = 1; if_en = 0; go_lsb(0, 32'h11, 2'b00, 0);
    @(negedge clk); rob_flush = 0; lsb_en = 0;
    repeat (10) @(negedge clk);
    go_if(32'h100); go_lsb(0, 32'h11, 2'b00, 0); rob_flush = 1;
    @(negedge clk); gap(); repeat (6) @(negedge clk);
    chk("flush if", n_if_ok, base_if); chk("flush lsb", n_lsb_ok, base_lsb);
    go_if(32'h100); go_lsb(1, 32'h40, 2'b00, 32'h5A); rob_flush = 1;
    wait_ok(0, "flush st", lat);
    chk("flush st lat", lat, 2); gap();

    // address wrap
    go_lsb(0, 32'hFFFF_FFFF, 2'b00, 0); wait_ok(0, "wrap b", lat);
    chk("wrap byte", lsb_rdata, 32'h0000_009A); gap();
    go_lsb(0, 32'hFFFF_FFFE, 2'b11, 0);
    for (int i = 0; i < 4; i++) begin @(negedge clk); seq[i] = mem_a; end
    wait_ok(0, "wrap w", lat);
    chk("wrap a0", seq[0], 32'hFFFF_FFFE); chk("wrap a1", seq[1], 32'hFFFF_FFFF);
    chk("wrap a2", seq[2], 32'h0000_0000); chk("wrap a3", seq[3], 32'h0000_0001);
    chk("wrap lat", lat, 2); chk("wrap word", lsb_rdata, 32'h2211_9A78); gap();

    // rdy low for two cycles mid-fetch
    go_if(32'h100); repeat (2) @(negedge clk);
    rdy = 0; repeat (2) @(negedge clk); rdy = 1;
    wait_ok(1, "rdy", lat);
    chk("rdy lat", lat, 4); chk("rdy word", if_data, 32'h0000_0513); gap();

    // reset mid-store: two bytes land, no ok
    base_lsb = n_lsb_ok;
    go_lsb(1, 32'h3000, 2'b11, 32'hCAFE_F00D); repeat (2) @(negedge clk);
    rst_n = 0; lsb_en = 0; @(negedge clk);
    chk("mrst mem_wr", mem_wr, 1'b0); chk("mrst mem_a", mem_a, 32'h0);
    chk("mrst lsb_rdata", lsb_rdata, 32'h0);
    rst_n = 1; gap();
    chk("mrst no ok", n_lsb_ok, base_lsb);
    go_lsb(0, 32'h3000, 2'b11, 0); wait_ok(0, "mrst ld", lat);
    chk("mrst partial", lsb_rdata, 32'h0000_F00D); gap();

    // IO store with the IO buffer full for three cycles
    io_buffer_full = 1; go_lsb(1, 32'h0003_0000, 2'b00, 32'h41); lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) io_buffer_full = 0;
      if (lsb_ok) begin lat = i; break; end
    end
    chk("io lat", lat, STALL ? 5 : 2); gap();
    go_lsb(0, 32'h0003_0000, 2'b00, 0); wait_ok(0, "io ld", lat);
    chk("io byte", lsb_rdata, 32'h0000_0041); gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
